cook_timer_ctrl: RTL and testbench

//  Sequencer for the microwave cook cycle. Owns the divide-by-100 timebase:

---
 rtl/cook_timer_ctrl_pkg.sv | 34 +++
 rtl/cook_timer_ctrl_if.sv | 30 +++
 rtl/cook_timer_ctrl_bcd_mmss_dec.sv | 32 +++
 rtl/cook_timer_ctrl.sv | 132 +++++++++++++
 tb/tb_cook_timer_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cook_timer_ctrl_pkg.sv
// Shared types and constants for the microwave cook-cycle sequencer.
// Time is held as four BCD digits, packed as {m1, m0, s1, s0}.
package microwave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef logic [3:0] bcd_digit_t;
    // Index 3 = minute tens, 2 = minute units, 1 = second tens, 0 = second units.
    typedef bcd_digit_t [3:0] mmss_t;

    localparam bcd_digit_t MAX_SEC_TENS = 4'd5;
    localparam bcd_digit_t DIGIT_MAX    = 4'd9;
    localparam mmss_t      MMSS_ZERO    = '0;

    // Clamp the minutes field to max_min (expected to be 0..99).
    function automatic mmss_t saturate_minutes(input mmss_t t, input int unsigned max_min);
        mmss_t       r;
        int unsigned minutes;
        r       = t;
        minutes = 32'(t[3]) * 32'd10 + 32'(t[2]);
        if (minutes > max_min) begin
            r[3] = 4'(max_min / 10);
            r[2] = 4'(max_min % 10);
        end
        return r;
    endfunction

endpackage

// File: rtl/cook_timer_ctrl_if.sv
// Keypad/door/tick inputs and display/magnetron outputs of the cook timer.
// slave = the controller, master = whoever drives the keypad side.
interface cook_timer_ctrl_if;
    import microwave_pkg::*;

    logic       tick_in;
    logic       key_valid;
    bcd_digit_t key_digit;
    logic       start;
    logic       stop_clear;
    logic       door_closed;
    logic       div_en;
    logic       div_clear;
    logic       mag_on;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       done;
    logic [2:0] state;

    modport slave (
        input  tick_in, key_valid, key_digit, start, stop_clear, door_closed,
        output div_en, div_clear, mag_on, min_bcd, sec_bcd, done, state
    );

    modport master (
        output tick_in, key_valid, key_digit, start, stop_clear, door_closed,
        input  div_en, div_clear, mag_on, min_bcd, sec_bcd, done, state
    );

endinterface

// File: rtl/cook_timer_ctrl_bcd_mmss_dec.sv
// Combinational one-second decrement of an MM:SS BCD value.
// Second tens wrap to 5, every other digit wraps to 9; o_is_zero flags a 00:00 result.
module bcd_mmss_dec
    import microwave_pkg::*;
(
    input  mmss_t i_time,
    output mmss_t o_time,
    output logic  o_is_zero
);

    logic [3:0] w_borrow;

    assign w_borrow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            localparam bcd_digit_t WRAP = (gi == 1) ? MAX_SEC_TENS : DIGIT_MAX;
            logic w_digit_zero;

            assign w_digit_zero = (i_time[gi] == 4'd0);
            assign o_time[gi]   = !w_borrow[gi] ? i_time[gi]
                                : (w_digit_zero ? WRAP : i_time[gi] - 4'd1);

            if (gi < 3) begin : g_chain
                assign w_borrow[gi+1] = w_borrow[gi] & w_digit_zero;
            end
        end
    endgenerate

    assign o_is_zero = (o_time == MMSS_ZERO);

endmodule

// File: rtl/cook_timer_ctrl.sv
// Microwave cook-cycle sequencer: keypad time entry, BCD countdown on the
// once-per-second tick, divider control, magnetron gating and completion flag.
module cook_timer_ctrl
    import microwave_pkg::*;
#(
    parameter int unsigned MAX_MIN   = 99,
    parameter int unsigned DONE_HOLD = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    cook_timer_ctrl_if.slave bus
);

    localparam int HOLD_W = (DONE_HOLD > 0) ? $clog2(DONE_HOLD + 1) : 1;

    state_t              r_state, w_state_next;
    mmss_t               r_time, w_time_next;
    logic [HOLD_W-1:0]   r_hold_cnt, w_hold_cnt_next;
    logic                r_div_en, r_div_clear, r_mag_on, r_done;
    logic                w_div_en_next, w_div_clear_next, w_mag_on_next, w_done_next;

    mmss_t               w_dec_time;
    logic                w_dec_zero;
    mmss_t               w_shifted;
    logic                w_key_ok;
    logic                w_start_ok;

    bcd_mmss_dec u_dec (
        .i_time    (r_time),
        .o_time    (w_dec_time),
        .o_is_zero (w_dec_zero)
    );

    assign w_key_ok   = bus.key_valid && (bus.key_digit <= DIGIT_MAX);
    assign w_start_ok = bus.start && bus.door_closed;
    assign w_shifted  = saturate_minutes({r_time[2], r_time[1], r_time[0], bus.key_digit},
                                         MAX_MIN);

    // Each branch tests events in priority order: stop_clear, door open, start, tick, key.
    always_comb begin
        w_state_next    = r_state;
        w_time_next     = r_time;
        w_hold_cnt_next = r_hold_cnt;

        case (r_state)
            ST_IDLE, ST_SET: begin
                if (bus.stop_clear) begin
                    w_state_next = ST_IDLE;
                    w_time_next  = MMSS_ZERO;
                end else if (r_state == ST_SET && w_start_ok) begin
                    w_state_next = ST_COOK;
                end else if (w_key_ok) begin
                    w_time_next  = w_shifted;
                    w_state_next = (w_shifted != MMSS_ZERO) ? ST_SET : ST_IDLE;
                end
            end
            ST_COOK: begin
                if (bus.stop_clear || !bus.door_closed) begin
                    w_state_next = ST_PAUSE;
                end else if (bus.tick_in) begin
                    w_time_next = w_dec_time;
                    if (w_dec_zero) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_PAUSE: begin
                if (bus.stop_clear) begin
                    w_state_next = ST_IDLE;
                    w_time_next  = MMSS_ZERO;
                end else if (w_start_ok) begin
                    w_state_next = ST_COOK;
                end
            end
            ST_DONE: begin
                if (bus.stop_clear || !bus.door_closed) begin
                    w_state_next = ST_IDLE;
                end else if ((DONE_HOLD > 0) && bus.tick_in) begin
                    if (r_hold_cnt == HOLD_W'(DONE_HOLD - 1)) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_hold_cnt_next = r_hold_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_time_next  = MMSS_ZERO;
            end
        endcase

        if (w_state_next != ST_DONE) begin
            w_hold_cnt_next = '0;
        end
    end

    // Magnetron and divider run only once COOK is established, so the entry cycle
    // carries just the divider clear and any exit drops them on the same edge.
    assign w_mag_on_next    = (r_state == ST_COOK) && (w_state_next == ST_COOK);
    assign w_div_en_next    = w_mag_on_next;
    assign w_div_clear_next = (r_state != ST_COOK) && (w_state_next == ST_COOK);
    assign w_done_next      = (w_state_next == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_time      <= MMSS_ZERO;
            r_hold_cnt  <= '0;
            r_div_en    <= 1'b0;
            r_div_clear <= 1'b0;
            r_mag_on    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_time      <= w_time_next;
            r_hold_cnt  <= w_hold_cnt_next;
            r_div_en    <= w_div_en_next;
            r_div_clear <= w_div_clear_next;
            r_mag_on    <= w_mag_on_next;
            r_done      <= w_done_next;
        end
    end

    assign bus.div_en    = r_div_en;
    assign bus.div_clear = r_div_clear;
    assign bus.mag_on    = r_mag_on;
    assign bus.done      = r_done;
    assign bus.state     = r_state;
    assign bus.min_bcd   = {r_time[3], r_time[2]};
    assign bus.sec_bcd   = {r_time[1], r_time[0]};

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Scoreboard bench for cook_timer_ctrl: an integer minutes/seconds model predicts
// every cycle's outputs, a monitor compares them, plus directed constant checks.
module tb_cook_timer_ctrl;

    localparam int TB_MAX_MIN = 99;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cook_timer_ctrl_if bus ();

    cook_timer_ctrl #(
        .MAX_MIN   (TB_MAX_MIN),
        .DONE_HOLD (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0] state;
        logic [7:0] min_bcd;
        logic [7:0] sec_bcd;
        logic       mag_on;
        logic       div_en;
        logic       div_clear;
        logic       done;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   mon_en  = 1'b0;
    bit   verbose = 1'b1;
    bit   door    = 1'b1;

    // Reference model: state code plus minutes/seconds as plain integers.
    int m_state = 0;
    int m_min   = 0;
    int m_sec   = 0;

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.state     = bus.state;
        o.min_bcd   = bus.min_bcd;
        o.sec_bcd   = bus.sec_bcd;
        o.mag_on    = bus.mag_on;
        o.div_en    = bus.div_en;
        o.div_clear = bus.div_clear;
        o.done      = bus.done;
        return o;
    endfunction

    function automatic obs_t model_step(input bit tk, input bit kv, input int kd,
                                        input bit st, input bit sc, input bit dr);
        obs_t e;
        int   prev;
        int   nm;
        int   ns;
        prev = m_state;
        case (m_state)
            0, 1: begin
                if (sc) begin
                    m_state = 0; m_min = 0; m_sec = 0;
                end else if (m_state == 1 && st && dr) begin
                    m_state = 2;
                end else if (kv && kd <= 9) begin
                    nm = (m_min % 10) * 10 + m_sec / 10;
                    ns = (m_sec % 10) * 10 + kd;
                    if (nm > TB_MAX_MIN) nm = TB_MAX_MIN;
                    m_min   = nm;
                    m_sec   = ns;
                    m_state = (nm + ns != 0) ? 1 : 0;
                end
            end
            2: begin
                if (sc || !dr) begin
                    m_state = 3;
                end else if (tk) begin
                    if (m_min == 0 && m_sec == 1) begin
                        m_sec = 0; m_state = 4;
                    end else if (m_sec > 0) begin
                        m_sec = m_sec - 1;
                    end else begin
                        m_min = m_min - 1; m_sec = 59;
                    end
                end
            end
            3: begin
                if (sc) begin
                    m_state = 0; m_min = 0; m_sec = 0;
                end else if (st && dr) begin
                    m_state = 2;
                end
            end
            default: begin
                if (sc || !dr) m_state = 0;
            end
        endcase
        e.state     = 3'(m_state);
        e.min_bcd   = to_bcd(m_min);
        e.sec_bcd   = to_bcd(m_sec);
        e.mag_on    = (prev == 2) && (m_state == 2);
        e.div_en    = (prev == 2) && (m_state == 2);
        e.div_clear = (prev != 2) && (m_state == 2);
        e.done      = (m_state == 4);
        return e;
    endfunction

    // One clock of stimulus; the prediction goes to the scoreboard queue.
    task automatic drive(input bit tk, input bit kv, input int kd, input bit st, input bit sc);
        obs_t e;
        @(negedge clk);
        bus.tick_in     = tk;
        bus.key_valid   = kv;
        bus.key_digit   = 4'(kd);
        bus.start       = st;
        bus.stop_clear  = sc;
        bus.door_closed = door;
        e = model_step(tk, kv, kd, st, sc, door);
        exp_q.push_back(e);
        @(posedge clk);
        #2;
        bus.tick_in    = 1'b0;
        bus.key_valid  = 1'b0;
        bus.start      = 1'b0;
        bus.stop_clear = 1'b0;
        cyc++;
    endtask

    task automatic key(input int d);
        drive(1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end else begin
            $display("[TB] check %s = %0h", name, got);
        end
    endtask

    task automatic check_time(input string name, input int mm, input int ss);
        check({name, "_min"}, 32'(bus.min_bcd), 32'(to_bcd(mm)));
        check({name, "_sec"}, 32'(bus.sec_bcd), 32'(to_bcd(ss)));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_state"}, 32'(bus.state), 0);
        check_time(name, 0, 0);
        check({name, "_mag"}, 32'(bus.mag_on), 0);
        check({name, "_en"}, 32'(bus.div_en), 0);
        check({name, "_clr"}, 32'(bus.div_clear), 0);
        check({name, "_done"}, 32'(bus.done), 0);
    endtask

    // Scoreboard monitor: one comparison per predicted cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && exp_q.size() > 0) begin
                obs_t e;
                obs_t a;
                e = exp_q.pop_front();
                a = dut_obs();
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cyc%0d scoreboard: got st=%0d %h:%h mag=%b en=%b clr=%b done=%b, expected st=%0d %h:%h mag=%b en=%b clr=%b done=%b",
                             cyc, a.state, a.min_bcd, a.sec_bcd, a.mag_on, a.div_en, a.div_clear, a.done,
                             e.state, e.min_bcd, e.sec_bcd, e.mag_on, e.div_en, e.div_clear, e.done);
                end else if (verbose) begin
                    $display("[TB] cyc%0d st=%0d %h:%h mag=%b en=%b clr=%b done=%b",
                             cyc, a.state, a.min_bcd, a.sec_bcd, a.mag_on, a.div_en, a.div_clear, a.done);
                end
            end
        end
    end

    initial begin
        bus.tick_in     = 1'b0;
        bus.key_valid   = 1'b0;
        bus.key_digit   = 4'd0;
        bus.start       = 1'b0;
        bus.stop_clear  = 1'b0;
        bus.door_closed = 1'b1;

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Out-of-range digit is ignored
        key(12);
        check("key12_state", 32'(bus.state), 0);

        // 01:30 entry, start, countdown across the seconds borrow
        key(1); key(3); key(0);
        check("entry_state", 32'(bus.state), 1);
        check_time("entry", 1, 30);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
        check("start_state", 32'(bus.state), 2);
        check("start_clr", 32'(bus.div_clear), 1);
        check("start_mag", 32'(bus.mag_on), 0);
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
        check("run_mag", 32'(bus.mag_on), 1);
        check("run_en", 32'(bus.div_en), 1);
        check("run_clr", 32'(bus.div_clear), 0);
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
        check_time("tick1", 1, 29);
        repeat (30) drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
        check_time("tick31", 0, 59);

        // Door opens with a tick: tick discarded, PAUSE, start ignored while open
        door = 1'b0;
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("door_state", 32'(bus.state), 3);
        check_time("door", 0, 59);
        check("door_mag", 32'(bus.mag_on), 0);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
        check("open_start_state", 32'(bus.state), 3);
        door = 1'b1;
        drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
        check("resume_state", 32'(bus.state), 2);
        check("resume_clr", 32'(bus.div_clear), 1);
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
        check("resume_mag", 32'(bus.mag_on), 1);

        // Asynchronous reset while cooking, away from any clock edge
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        m_state = 0; m_min = 0; m_sec = 0;
        #1 rst_n = 1'b1;

        // 00:02 runs out to DONE, then acknowledged
        key(2);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("done_state", 32'(bus.state), 4);
        check_time("done", 0, 0);
        check("done_flag", 32'(bus.done), 1);
        check("done_mag", 32'(bus.mag_on), 0);
        check("done_en", 32'(bus.div_en), 0);
        drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
        check("ack_state", 32'(bus.state), 0);
        check("ack_done", 32'(bus.done), 0);

        // Start at 00:00 ignored; start with stop_clear in SET clears
        drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
        check("zero_start_state", 32'(bus.state), 0);
        key(5);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        check("start_stop_state", 32'(bus.state), 0);
        check_time("start_stop", 0, 0);

        // Full-width entry and a minutes borrow from 10:00
        key(9); key(9); key(5); key(9);
        check_time("max", 99, 59);
        key(9);
        check_time("shift_out", 95, 99);
        drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
        key(1); key(0); key(0); key(0);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
        check_time("min_borrow", 9, 59);
        drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 0, 1'b0, 1'b1);

        // Randomized traffic, scoreboard-checked every cycle
        verbose = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            int kd;
            door = ($urandom_range(0, 19) != 0);
            kd   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15))
                                                : int'($urandom_range(0, 2));
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 2, kd,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
        end

        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
